// File: rtl/dmem_router.sv
// dmem_router: routes core data requests to the CLINT or the AXI bridge, with alignment check and AXI timeout
module dmem_router #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_valid,
  input  logic        core_req,
  input  logic [63:0] core_addr,
  input  logic [1:0]  core_size,
  input  logic [63:0] core_data_write,
  output logic        core_ready,
  output logic [63:0] core_data_read,
  output logic [1:0]  core_resp,
  output logic        clint_valid,
  output logic        clint_req,
  output logic [63:0] clint_addr,
  output logic [1:0]  clint_size,
  output logic [63:0] clint_data_write,
  input  logic        clint_ready,
  input  logic [63:0] clint_data_read,
  input  logic [1:0]  clint_resp,
  output logic        axi_valid,
  output logic        axi_req,
  output logic [63:0] axi_addr,
  output logic [1:0]  axi_size,
  output logic [63:0] axi_data_write,
  input  logic        axi_ready,
  input  logic [63:0] axi_data_read,
  input  logic [1:0]  axi_resp
);
  localparam logic REQ_WRITE = 1'b1;
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, CLINT, AXI, DONE} state_t;
  state_t state_q, state_d;
  logic [63:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0] size_q, size_d, resp_q, resp_d;
  logic req_q, req_d, ready_q, ready_d, cv_q, cv_d, av_q, av_d;
  logic [7:0] cnt_q, cnt_d;
  logic mis, in_clint, unused_in;
  // The CLINT always answers in the cycle it is addressed, so its ready is not consulted
  assign unused_in = clint_ready;
  // Request classification on the incoming core fields
  always_comb begin
    mis = |(core_addr[2:0] & 3'((4'd1 << core_size) - 4'd1));
    in_clint = core_addr[63:16] == 48'h0000_0000_0200;
  end
  // Next-state logic; response data/resp/strobe default to zero so they only show in DONE
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    size_d = size_q;
    req_d = req_q;
    wdata_d = wdata_q;
    cnt_d = cnt_q;
    ready_d = 1'b0;
    rdata_d = '0;
    resp_d = 2'b00;
    cv_d = 1'b0;
    av_d = 1'b0;
    case (state_q)
      IDLE: if (core_valid) begin
        addr_d = core_addr;
        size_d = core_size;
        req_d = core_req;
        wdata_d = core_data_write;
        cnt_d = '0;
        state_d = mis ? DONE : in_clint ? CLINT : AXI;
        ready_d = mis;
        resp_d = mis ? 2'b10 : 2'b00;
        cv_d = !mis && in_clint;
        av_d = !mis && !in_clint;
      end
      CLINT: begin
        state_d = DONE;
        ready_d = 1'b1;
        rdata_d = req_q == REQ_WRITE ? '0 : clint_data_read;
        resp_d = clint_resp;
      end
      AXI: if (axi_ready || cnt_q == LAST_WAIT) begin
        state_d = DONE;
        ready_d = 1'b1;
        rdata_d = (axi_ready && req_q != REQ_WRITE) ? axi_data_read : '0;
        resp_d = axi_ready ? axi_resp : 2'b10;
      end else begin
        av_d = 1'b1;
        cnt_d = cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  // State, request and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      size_q <= '0;
      req_q <= 1'b0;
      wdata_q <= '0;
      cnt_q <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      resp_q <= '0;
      cv_q <= 1'b0;
      av_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      size_q <= size_d;
      req_q <= req_d;
      wdata_q <= wdata_d;
      cnt_q <= cnt_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      resp_q <= resp_d;
      cv_q <= cv_d;
      av_q <= av_d;
    end
  end
  assign core_ready = ready_q;
  assign core_data_read = rdata_q;
  assign core_resp = resp_q;
  assign clint_valid = cv_q;
  assign clint_req = cv_q & req_q;
  assign clint_addr = cv_q ? addr_q : '0;
  assign clint_size = cv_q ? size_q : '0;
  assign clint_data_write = cv_q ? wdata_q : '0;
  assign axi_valid = av_q;
  assign axi_req = av_q & req_q;
  assign axi_addr = av_q ? addr_q : '0;
  assign axi_size = av_q ? size_q : '0;
  assign axi_data_write = av_q ? wdata_q : '0;
endmodule
